stride_walker: RTL and testbench

Bus initiator that drives the stride-address peripheral: for every (i, j) in a rows × cols grid it writes the packed index pair to the peripheral's register at 0x40000, reads back the computed element address, and emits it on a valid/ready output stream. It sits between a control source (core-side CSR or sequencer) and the same single-cycle req/rvalid device bus the peripheral responds on. It turns one start pulse into a stream of strided addresses without core involvement.

---
 rtl/stride_walker_pkg.sv | 22 ++
 rtl/stride_walker_if.sv | 37 +++
 rtl/stride_idx_gen.sv | 53 +++++
 rtl/stride_walker.sv | 165 ++++++++++++++++
 tb/tb_stride_walker.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stride_walker_pkg.sv
// Shared types and constants for the stride-address walker.
package stride_walker_pkg;

    localparam int unsigned IDX_W = 16;

    localparam logic [31:0] STRIDE_ADDR = 32'h0004_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_WAIT,
        S_RD,
        S_RD_WAIT,
        S_OUT
    } walk_state_e;

    // Index pair as the peripheral expects it: j in the upper half, i in the lower half.
    function automatic logic [31:0] pack_idx(input logic [IDX_W-1:0] i, input logic [IDX_W-1:0] j);
        return {j, i};
    endfunction

endpackage

// File: rtl/stride_walker_if.sv
// Device-bus initiator port plus the element output stream of the walker.
interface stride_walker_if
    import stride_walker_pkg::*;
#(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32
);
    logic                    host_req;
    logic [AddressWidth-1:0] host_addr;
    logic                    host_we;
    logic [DataWidth/8-1:0]  host_be;
    logic [DataWidth-1:0]    host_wdata;
    logic                    host_rvalid;
    logic [DataWidth-1:0]    host_rdata;
    logic                    host_err;

    logic                    out_valid;
    logic                    out_ready;
    logic [DataWidth-1:0]    out_addr;
    logic [IDX_W-1:0]        out_i;
    logic [IDX_W-1:0]        out_j;

    modport master (
        output host_req, host_addr, host_we, host_be, host_wdata,
        input  host_rvalid, host_rdata, host_err,
        output out_valid, out_addr, out_i, out_j,
        input  out_ready
    );

    modport slave (
        input  host_req, host_addr, host_we, host_be, host_wdata,
        output host_rvalid, host_rdata, host_err,
        input  out_valid, out_addr, out_i, out_j,
        output out_ready
    );

endinterface

// File: rtl/stride_idx_gen.sv
// 2D index counter: i runs fastest, j steps when i wraps; extents latched on clear.
module stride_idx_gen #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             advance_i,
    input  logic [Width-1:0] rows_i,
    input  logic [Width-1:0] cols_i,
    output logic [Width-1:0] i_o,
    output logic [Width-1:0] j_o,
    output logic [Width-1:0] nxt_i_o,
    output logic [Width-1:0] nxt_j_o,
    output logic             last_o
);

    logic [Width-1:0] rows_q;
    logic [Width-1:0] cols_q;
    logic [Width-1:0] i_q;
    logic [Width-1:0] j_q;
    logic             i_wrap;

    // Successor indices and end-of-grid detection from the latched extents.
    always_comb begin
        i_wrap  = (i_q == rows_q - Width'(1));
        nxt_i_o = i_wrap ? '0 : i_q + Width'(1);
        nxt_j_o = i_wrap ? j_q + Width'(1) : j_q;
        last_o  = i_wrap && (j_q == cols_q - Width'(1));
    end

    // Extent latch and index registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rows_q <= '0;
            cols_q <= '0;
            i_q    <= '0;
            j_q    <= '0;
        end else if (clear_i) begin
            rows_q <= rows_i;
            cols_q <= cols_i;
            i_q    <= '0;
            j_q    <= '0;
        end else if (advance_i) begin
            i_q <= nxt_i_o;
            j_q <= nxt_j_o;
        end
    end

    assign i_o = i_q;
    assign j_o = j_q;

endmodule

// File: rtl/stride_walker.sv
// Walks a rows x cols grid through the stride peripheral: write index pair,
// read back the element address, hand it out on a valid/ready stream.
module stride_walker
    import stride_walker_pkg::*;
#(
    parameter int unsigned             DataWidth    = 32,
    parameter int unsigned             AddressWidth = 32,
    parameter logic [AddressWidth-1:0] StrideAddr   = AddressWidth'(STRIDE_ADDR)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [IDX_W-1:0] rows_i,
    input  logic [IDX_W-1:0] cols_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    stride_walker_if.master  bus
);

    if (DataWidth != 32) begin : g_width_check
        $error("stride_walker: DataWidth must be 32");
    end

    walk_state_e      state_q;
    walk_state_e      state_d;
    logic             idx_clear;
    logic             idx_adv;
    logic             idx_last;
    logic             walk_end;
    logic             start_ok;
    logic             set_err;
    logic [IDX_W-1:0] idx_i;
    logic [IDX_W-1:0] idx_j;
    logic [IDX_W-1:0] nxt_i;
    logic [IDX_W-1:0] nxt_j;
    logic [IDX_W-1:0] wr_i;
    logic [IDX_W-1:0] wr_j;

    stride_idx_gen #(
        .Width(IDX_W)
    ) u_idx (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (idx_clear),
        .advance_i(idx_adv),
        .rows_i   (rows_i),
        .cols_i   (cols_i),
        .i_o      (idx_i),
        .j_o      (idx_j),
        .nxt_i_o  (nxt_i),
        .nxt_j_o  (nxt_j),
        .last_o   (idx_last)
    );

    // Next-state logic; also decides counter control and walk termination.
    always_comb begin
        state_d   = state_q;
        idx_clear = 1'b0;
        idx_adv   = 1'b0;
        walk_end  = 1'b0;
        start_ok  = 1'b0;
        set_err   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    start_ok  = 1'b1;
                    idx_clear = 1'b1;
                    if (rows_i == '0 || cols_i == '0) begin
                        walk_end = 1'b1;
                    end else begin
                        state_d = S_WR;
                    end
                end
            end
            S_WR:      state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                if (bus.host_rvalid) begin
                    if (bus.host_err) begin
                        set_err  = 1'b1;
                        walk_end = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD:      state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (bus.host_rvalid) begin
                    if (bus.host_err) begin
                        set_err  = 1'b1;
                        walk_end = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    if (idx_last) begin
                        walk_end = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        idx_adv = 1'b1;
                        state_d = S_WR;
                    end
                end
            end
            default:   state_d = S_IDLE;
        endcase
        // Outputs are registered, so the write payload uses the indices the
        // counter will hold once the transition into WR has happened.
        wr_i = start_ok ? '0 : nxt_i;
        wr_j = start_ok ? '0 : nxt_j;
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered status, bus request and output stream, derived from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
            bus.host_req   <= 1'b0;
            bus.host_we    <= 1'b0;
            bus.host_be    <= '0;
            bus.host_wdata <= '0;
            bus.host_addr  <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_addr   <= '0;
            bus.out_i      <= '0;
            bus.out_j      <= '0;
        end else begin
            busy_o         <= (state_d != S_IDLE);
            done_o         <= walk_end;
            if (start_ok) begin
                err_o <= 1'b0;
            end else if (set_err) begin
                err_o <= 1'b1;
            end
            bus.host_req   <= (state_d == S_WR) || (state_d == S_RD);
            bus.host_we    <= (state_d == S_WR);
            bus.host_be    <= (state_d == S_WR) ? '1 : '0;
            bus.host_wdata <= (state_d == S_WR) ? DataWidth'(pack_idx(wr_i, wr_j)) : '0;
            bus.host_addr  <= ((state_d == S_WR) || (state_d == S_RD)) ? StrideAddr : '0;
            bus.out_valid  <= (state_d == S_OUT);
            if (state_q == S_RD_WAIT && bus.host_rvalid) begin
                bus.out_addr <= bus.host_rdata;
                bus.out_i    <= idx_i;
                bus.out_j    <= idx_j;
            end
        end
    end

endmodule

// File: tb/tb_stride_walker.sv
// Directed bench for stride_walker with a one-cycle stride peripheral model
// computing 0x40000 + 2i + 2j.
module tb_stride_walker;
    import stride_walker_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] rows;
    logic [15:0] cols;
    logic        busy;
    logic        done;
    logic        err;

    stride_walker_if #(.DataWidth(32), .AddressWidth(32)) bus ();

    stride_walker #(
        .DataWidth   (32),
        .AddressWidth(32),
        .StrideAddr  (32'h0004_0000)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .start_i(start),
        .rows_i (rows),
        .cols_i (cols),
        .busy_o (busy),
        .done_o (done),
        .err_o  (err),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- peripheral model ----------------
    int unsigned rd_delay      = 1;
    logic        err_en        = 1'b0;
    logic [31:0] err_target    = 32'h0;
    logic [31:0] periph_result = 32'h0;
    logic [31:0] last_idx      = 32'h0;
    int unsigned pend_cnt      = 0;
    logic [31:0] pend_data     = 32'h0;
    logic        pend_err      = 1'b0;

    always @(negedge clk) begin
        bus.host_rvalid <= 1'b0;
        bus.host_err    <= 1'b0;
        bus.host_rdata  <= 32'h0;
        if (pend_cnt == 1) begin
            bus.host_rvalid <= 1'b1;
            bus.host_rdata  <= pend_data;
            bus.host_err    <= pend_err;
        end
        if (pend_cnt != 0) pend_cnt <= pend_cnt - 1;
        if (bus.host_req) begin
            if (bus.host_we) begin
                periph_result <= 32'h0004_0000 + (32'(bus.host_wdata[15:0]) << 1)
                                                + (32'(bus.host_wdata[31:16]) << 1);
                last_idx  <= bus.host_wdata;
                pend_data <= 32'h0;
                pend_err  <= 1'b0;
                pend_cnt  <= 1;
            end else begin
                pend_data <= periph_result;
                pend_err  <= err_en && (last_idx == err_target);
                pend_cnt  <= rd_delay;
            end
        end
    end

    // ---------------- monitor ----------------
    int unsigned req_cnt = 0, rd_cnt = 0, done_cnt = 0, busy_cycles = 0, proto_bad = 0;
    logic [31:0] wr_q[$];
    logic [31:0] oaddr_q[$];
    logic [15:0] oi_q[$];
    logic [15:0] oj_q[$];
    int unsigned ocyc_q[$];
    int unsigned reqcyc_q[$];
    int unsigned donecyc_q[$];

    always begin
        @(negedge clk);
        #2;
        if (bus.host_req) begin
            req_cnt <= req_cnt + 1;
            reqcyc_q.push_back(cyc);
            if (bus.host_addr != 32'h0004_0000) proto_bad <= proto_bad + 1;
            if (bus.host_we) begin
                wr_q.push_back(bus.host_wdata);
                if (bus.host_be != 4'hF) proto_bad <= proto_bad + 1;
            end else begin
                rd_cnt <= rd_cnt + 1;
                if (bus.host_be != 4'h0 || bus.host_wdata != 32'h0) proto_bad <= proto_bad + 1;
            end
        end
        if (bus.out_valid && bus.out_ready) begin
            oaddr_q.push_back(bus.out_addr);
            oi_q.push_back(bus.out_i);
            oj_q.push_back(bus.out_j);
            ocyc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            donecyc_q.push_back(cyc);
        end
        if (busy) busy_cycles <= busy_cycles + 1;
    end

    // ---------------- checking helpers ----------------
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    int unsigned b_req, b_rd, b_done, b_busy, b_wr, b_out, b_reqc, b_donec;

    task automatic snap();
        b_req   = req_cnt;
        b_rd    = rd_cnt;
        b_done  = done_cnt;
        b_busy  = busy_cycles;
        b_wr    = wr_q.size();
        b_out   = oaddr_q.size();
        b_reqc  = reqcyc_q.size();
        b_donec = donecyc_q.size();
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int unsigned k = 0; k < 400; k++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    // Start a walk; extents are scrambled after acceptance to show they are latched.
    task automatic do_walk(input logic [15:0] r, input logic [15:0] c,
                           output int unsigned start_cyc, output bit ok);
        @(negedge clk);
        rows      = r;
        cols      = c;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        rows  = 16'($urandom);
        cols  = 16'($urandom);
        wait_done(ok);
    endtask

    typedef struct {
        logic [15:0] rows;
        logic [15:0] cols;
        int unsigned elems;
        logic [31:0] last_addr;
    } walk_vec_t;

    walk_vec_t   tbl[6];
    logic [31:0] exp_wr[6];
    logic [31:0] exp_addr[6];
    logic [15:0] exp_i[6];
    logic [15:0] exp_j[6];
    int unsigned sc;
    int unsigned rq0;
    bit          ok;

    initial begin
        tbl[0] = '{rows: 16'd2, cols: 16'd2, elems: 4, last_addr: 32'h0004_0004};
        tbl[1] = '{rows: 16'd1, cols: 16'd1, elems: 1, last_addr: 32'h0004_0000};
        tbl[2] = '{rows: 16'd3, cols: 16'd1, elems: 3, last_addr: 32'h0004_0004};
        tbl[3] = '{rows: 16'd1, cols: 16'd4, elems: 4, last_addr: 32'h0004_0006};
        tbl[4] = '{rows: 16'd0, cols: 16'd5, elems: 0, last_addr: 32'h0};
        tbl[5] = '{rows: 16'd4, cols: 16'd0, elems: 0, last_addr: 32'h0};
        exp_wr   = '{32'h0000_0000, 32'h0000_0001, 32'h0001_0000, 32'h0001_0001, 32'h0002_0000, 32'h0002_0001};
        exp_addr = '{32'h0004_0000, 32'h0004_0002, 32'h0004_0002, 32'h0004_0004, 32'h0004_0004, 32'h0004_0006};
        exp_i    = '{16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1};
        exp_j    = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd2};

        rst_n = 1'b0;
        start = 1'b0;
        rows  = 16'd0;
        cols  = 16'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_req", bus.host_req, 0);
        check("rst_we", bus.host_we, 0);
        check("rst_be", bus.host_be, 0);
        check("rst_wdata", bus.host_wdata, 0);
        check("rst_addr", bus.host_addr, 0);
        check("rst_out_addr", bus.out_addr, 0);
        check("rst_out_i", bus.out_i, 0);
        check("rst_out_j", bus.out_j, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of walks with ready held high
        for (int unsigned t = 0; t < 6; t++) begin
            snap();
            do_walk(tbl[t].rows, tbl[t].cols, sc, ok);
            check($sformatf("tbl%0d_finished", t), ok, 1);
            check($sformatf("tbl%0d_done_cnt", t), done_cnt - b_done, 1);
            check($sformatf("tbl%0d_elems", t), oaddr_q.size() - b_out, tbl[t].elems);
            check($sformatf("tbl%0d_reqs", t), req_cnt - b_req, 2 * tbl[t].elems);
            check($sformatf("tbl%0d_busy_cycles", t), busy_cycles - b_busy, 5 * tbl[t].elems);
            check($sformatf("tbl%0d_err", t), err, 0);
            if (tbl[t].elems != 0 && oaddr_q.size() > b_out)
                check($sformatf("tbl%0d_last_addr", t), oaddr_q[oaddr_q.size() - 1], tbl[t].last_addr);
        end

        // 2 x 3 walk: write order, address order, indices and timing
        snap();
        do_walk(16'd2, 16'd3, sc, ok);
        check("g23_finished", ok, 1);
        check("g23_writes", wr_q.size() - b_wr, 6);
        check("g23_elems", oaddr_q.size() - b_out, 6);
        for (int unsigned k = 0; k < 6; k++) begin
            if (b_wr + k < wr_q.size())
                check($sformatf("g23_wdata%0d", k), wr_q[b_wr + k], exp_wr[k]);
            if (b_out + k < oaddr_q.size()) begin
                check($sformatf("g23_addr%0d", k), oaddr_q[b_out + k], exp_addr[k]);
                check($sformatf("g23_i%0d", k), oi_q[b_out + k], exp_i[k]);
                check($sformatf("g23_j%0d", k), oj_q[b_out + k], exp_j[k]);
                if (k > 0)
                    check($sformatf("g23_period%0d", k), ocyc_q[b_out + k] - ocyc_q[b_out + k - 1], 5);
            end
        end
        if (reqcyc_q.size() > b_reqc) check("g23_first_wr_cycle", reqcyc_q[b_reqc] - sc, 1);
        if (ocyc_q.size() > b_out) check("g23_first_out_cycle", ocyc_q[b_out] - sc, 5);
        if (donecyc_q.size() > b_donec) check("g23_done_cycle", donecyc_q[b_donec] - sc, 31);
        check("g23_done_cnt", done_cnt - b_done, 1);
        check("g23_err", err, 0);

        // Empty grid: done one cycle after start, no traffic, never busy
        snap();
        do_walk(16'd0, 16'd5, sc, ok);
        check("zero_finished", ok, 1);
        if (donecyc_q.size() > b_donec) check("zero_done_cycle", donecyc_q[b_donec] - sc, 1);
        check("zero_reqs", req_cnt - b_req, 0);
        check("zero_busy", busy_cycles - b_busy, 0);

        // Backpressure on the first element
        snap();
        bus.out_ready = 1'b0;
        @(negedge clk);
        rows  = 16'd1;
        cols  = 16'd2;
        start = 1'b1;
        sc    = cyc;
        @(negedge clk);
        start = 1'b0;
        ok    = 1'b0;
        for (int unsigned k = 0; k < 50; k++) begin
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("bp_valid_seen", ok, 1);
        check("bp_valid_cycle", cyc - sc, 5);
        rq0 = req_cnt;
        for (int unsigned k = 0; k < 10; k++) begin
            check($sformatf("bp_hold_valid%0d", k), bus.out_valid, 1);
            check($sformatf("bp_hold_addr%0d", k), bus.out_addr, 32'h0004_0000);
            @(negedge clk);
        end
        check("bp_no_req", req_cnt - rq0, 0);
        bus.out_ready = 1'b1;
        wait_done(ok);
        check("bp_finished", ok, 1);
        check("bp_elems", oaddr_q.size() - b_out, 2);
        if (oaddr_q.size() >= b_out + 2) check("bp_addr1", oaddr_q[b_out + 1], 32'h0004_0002);
        check("bp_done_cnt", done_cnt - b_done, 1);

        // Read error on element (1,0)
        err_target = 32'h0000_0001;
        err_en     = 1'b1;
        snap();
        do_walk(16'd2, 16'd2, sc, ok);
        check("err_finished", ok, 1);
        check("err_flag", err, 1);
        check("err_elems", oaddr_q.size() - b_out, 1);
        check("err_done_cnt", done_cnt - b_done, 1);
        repeat (5) @(negedge clk);
        check("err_reqs", req_cnt - b_req, 4);
        check("err_sticky", err, 1);
        err_en = 1'b0;

        snap();
        @(negedge clk);
        rows  = 16'd1;
        cols  = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_cleared", err, 0);
        wait_done(ok);
        check("err_rerun_finished", ok, 1);
        check("err_rerun_elems", oaddr_q.size() - b_out, 1);
        if (oaddr_q.size() > b_out) check("err_rerun_addr", oaddr_q[b_out], 32'h0004_0000);
        check("err_rerun_err", err, 0);

        // Reset during RD_WAIT with a late read response
        rd_delay = 6;
        snap();
        @(negedge clk);
        rows  = 16'd2;
        cols  = 16'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok    = 1'b0;
        for (int unsigned k = 0; k < 50; k++) begin
            if (bus.host_req && !bus.host_we) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rstw_read_seen", ok, 1);
        @(negedge clk);
        check("rstw_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rstw_req", bus.host_req, 0);
        check("rstw_busy", busy, 0);
        check("rstw_valid", bus.out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("rstw_late_busy", busy, 0);
        check("rstw_late_valid", bus.out_valid, 0);
        check("rstw_late_done", done_cnt - b_done, 0);
        check("rstw_late_elems", oaddr_q.size() - b_out, 0);
        check("rstw_late_reqs", req_cnt - b_req, 2);
        rd_delay = 1;
        snap();
        do_walk(16'd1, 16'd1, sc, ok);
        check("rstw_rerun_finished", ok, 1);
        check("rstw_rerun_elems", oaddr_q.size() - b_out, 1);
        if (oaddr_q.size() > b_out) check("rstw_rerun_addr", oaddr_q[b_out], 32'h0004_0000);

        // start_i held every cycle of a 1 x 1 walk
        snap();
        ok = 1'b0;
        for (int unsigned k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done) begin
                start = 1'b0;
                ok    = 1'b1;
                break;
            end
            rows  = 16'd1;
            cols  = 16'd1;
            start = 1'b1;
        end
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("spam_finished", ok, 1);
        check("spam_writes", wr_q.size() - b_wr, 1);
        check("spam_reads", rd_cnt - b_rd, 1);
        check("spam_done_cnt", done_cnt - b_done, 1);
        check("spam_elems", oaddr_q.size() - b_out, 1);

        check("bus_protocol", proto_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
